// File: rtl/haar_pkg.sv
// Shared types and width helpers for the Haar level extractor and its coefficient store.
package haar_pkg;

  typedef enum logic [2:0] {IDLE, ACCUM, SEARCH_Q, SEARCH_S, DONE} state_t;

  // Never returns less than 1, so a single-coefficient record still gets a 1-bit index.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int coef_w(input int data_w, input int level);
    return data_w + level;
  endfunction

endpackage

// File: rtl/haar_level_extract_ram.sv
// cA/cD coefficient buffers: one write port, a cD read port for the searches and a cA readback port.
module coef_ram #(
  parameter int N  = 16,
  parameter int W  = 19,
  parameter int AW = 4
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                i_we,
  input  logic [AW-1:0]       i_waddr,
  input  logic signed [W-1:0] i_wa,
  input  logic signed [W-1:0] i_wd,
  input  logic [AW-1:0]       i_sr_addr,
  output logic signed [W-1:0] o_sr_data,
  input  logic [AW-1:0]       i_rd_addr,
  output logic signed [W-1:0] o_rd_data
);

  logic signed [W-1:0] r_ca [N];
  logic signed [W-1:0] r_cd [N];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_ca[i_waddr] <= i_wa;
      r_cd[i_waddr] <= i_wd;
    end
    if (int'(i_sr_addr) < N) o_sr_data <= r_cd[i_sr_addr];
  end

  always_ff @(posedge clk) begin
    if (Reset)                     o_rd_data <= '0;
    else if (int'(i_rd_addr) < N)  o_rd_data <= r_ca[i_rd_addr];
    else                           o_rd_data <= '0;
  end

endmodule

// File: rtl/haar_level_extract.sv
// Level-LEVEL Haar decimator with global cD extrema tracking and Q-onset / S-end window searches.
module haar_level_extract import haar_pkg::*; #(
  parameter  int DATA_W = 16,
  parameter  int LEVEL  = 3,
  parameter  int N_COEF = 100,
  parameter  int Q_WIN  = 4,
  parameter  int S_WIN  = 4,
  localparam int IDX_W  = clog2(N_COEF),
  localparam int COEF_W = coef_w(DATA_W, LEVEL)
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     busy,
  output logic                     done,
  output logic [IDX_W-1:0]         max_pos,
  output logic [IDX_W-1:0]         min_pos,
  output logic [IDX_W-1:0]         q_begin,
  output logic                     q_flag,
  output logic                     q_empty,
  output logic [IDX_W-1:0]         s_end,
  output logic                     s_flag,
  output logic                     s_empty,
  input  logic [IDX_W-1:0]         rd_addr,
  output logic signed [COEF_W-1:0] rd_data
);

  localparam int HALF  = 1 << (LEVEL - 1);
  localparam int CNT_W = IDX_W + 1;

  state_t r_state, w_next;
  logic [LEVEL-1:0] r_samp;
  logic [IDX_W-1:0] r_k, r_max_pos, r_min_pos, r_q_begin, r_s_end, r_best_idx;
  logic signed [COEF_W-1:0] r_s0, r_s1, r_max, r_min, r_best;
  logic [CNT_W-1:0] r_cnt;
  logic r_q_flag, r_q_empty, r_s_flag, r_s_empty;

  logic w_acc, w_blk_end, w_last, w_restart, w_srch, w_srch_end, w_take;
  logic signed [COEF_W-1:0] w_x, w_s1n, w_ca, w_cd, w_sdata;
  logic [IDX_W-1:0] w_first, w_lastx, w_lo, w_cand, w_res, w_sr_addr;
  int w_lo_i, w_len;

  assign w_x       = COEF_W'(in_data);
  assign w_acc     = in_valid && (r_state == ACCUM);
  assign w_blk_end = w_acc && (&r_samp);
  assign w_last    = w_blk_end && (int'(r_k) == N_COEF - 1);
  assign w_restart = start && (r_state == IDLE || r_state == DONE);
  // The block's last sample always lands in S1, so fold it in before forming cA/cD.
  assign w_s1n     = r_s1 + w_x;
  assign w_ca      = r_s0 + w_s1n;
  assign w_cd      = r_s0 - w_s1n;

  // Window bounds; an empty window naturally yields w_len == 0.
  always_comb begin
    w_first = (r_max_pos < r_min_pos) ? r_max_pos : r_min_pos;
    w_lastx = (r_max_pos < r_min_pos) ? r_min_pos : r_max_pos;
    if (r_state == SEARCH_S) begin
      w_lo_i = int'(w_lastx) + 1;
      w_len  = ((int'(w_lastx) + S_WIN > N_COEF - 1) ? N_COEF - 1 : int'(w_lastx) + S_WIN)
               - int'(w_lastx);
    end else begin
      w_lo_i = (int'(w_first) > Q_WIN) ? int'(w_first) - Q_WIN : 0;
      w_len  = int'(w_first) - w_lo_i;
    end
  end

  assign w_lo       = IDX_W'(w_lo_i);
  assign w_srch     = (r_state == SEARCH_Q) || (r_state == SEARCH_S);
  assign w_srch_end = w_srch && (int'(r_cnt) == w_len);
  assign w_sr_addr  = w_lo + IDX_W'(r_cnt);
  // Read data lags the address by one cycle, so it belongs to index lo + cnt - 1.
  assign w_cand     = w_lo + IDX_W'(r_cnt - CNT_W'(1));
  assign w_take     = (int'(r_cnt) == 1) ||
                      ((r_state == SEARCH_Q) ? (w_sdata > r_best) : (w_sdata < r_best));
  assign w_res      = (w_len == 0) ? ((r_state == SEARCH_Q) ? w_first : w_lastx)
                                   : (w_take ? w_cand : r_best_idx);

  always_ff @(posedge clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (start)      w_next = ACCUM;
      ACCUM:      if (w_last)     w_next = SEARCH_Q;
      SEARCH_Q:   if (w_srch_end) w_next = SEARCH_S;
      SEARCH_S:   if (w_srch_end) w_next = DONE;
      default:                    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_samp <= '0;  r_k <= '0;  r_s0 <= '0;  r_s1 <= '0;
      r_max <= '0;  r_min <= '0;  r_max_pos <= '0;  r_min_pos <= '0;
      r_cnt <= '0;  r_best <= '0;  r_best_idx <= '0;
      r_q_begin <= '0;  r_q_flag <= 1'b0;  r_q_empty <= 1'b0;
      r_s_end <= '0;  r_s_flag <= 1'b0;  r_s_empty <= 1'b0;
    end else begin
      if (w_restart) begin
        r_samp <= '0;  r_k <= '0;  r_s0 <= '0;  r_s1 <= '0;
        r_q_flag <= 1'b0;  r_q_empty <= 1'b0;  r_s_flag <= 1'b0;  r_s_empty <= 1'b0;
      end
      if (w_acc) begin
        if (w_blk_end) begin
          r_samp <= '0;  r_s0 <= '0;  r_s1 <= '0;
          r_k    <= r_k + IDX_W'(1);
          if (r_k == '0) begin
            r_max <= w_cd;  r_min <= w_cd;  r_max_pos <= '0;  r_min_pos <= '0;
          end else if (w_cd > r_max) begin
            r_max <= w_cd;  r_max_pos <= r_k;
          end else if (w_cd < r_min) begin
            r_min <= w_cd;  r_min_pos <= r_k;
          end
        end else begin
          r_samp <= r_samp + LEVEL'(1);
          if (int'(r_samp) < HALF) r_s0 <= r_s0 + w_x;
          else                     r_s1 <= w_s1n;
        end
      end
      r_cnt <= (w_srch && !w_srch_end) ? r_cnt + CNT_W'(1) : '0;
      if (w_srch && r_cnt != '0 && w_take) begin
        r_best <= w_sdata;  r_best_idx <= w_cand;
      end
      if (w_srch_end) begin
        if (r_state == SEARCH_Q) begin
          r_q_begin <= w_res;  r_q_empty <= (w_len == 0);  r_q_flag <= 1'b1;
        end else begin
          r_s_end <= w_res;  r_s_empty <= (w_len == 0);  r_s_flag <= 1'b1;
        end
      end
    end
  end

  coef_ram #(.N(N_COEF), .W(COEF_W), .AW(IDX_W)) u_ram (
    .clk       (clk),
    .Reset     (Reset),
    .i_we      (w_blk_end),
    .i_waddr   (r_k),
    .i_wa      (w_ca),
    .i_wd      (w_cd),
    .i_sr_addr (w_sr_addr),
    .o_sr_data (w_sdata),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data)
  );

  assign in_ready = (r_state == ACCUM);
  assign busy     = (r_state == ACCUM) || w_srch;
  assign done     = (r_state == DONE);
  assign max_pos  = r_max_pos;
  assign min_pos  = r_min_pos;
  assign q_begin  = r_q_begin;
  assign q_flag   = r_q_flag;
  assign q_empty  = r_q_empty;
  assign s_end    = r_s_end;
  assign s_flag   = r_s_flag;
  assign s_empty  = r_s_empty;

endmodule

// File: tb/tb_haar_level_extract.sv
// Randomised and directed bench for haar_level_extract against a plain-arithmetic record model.
module tb_haar_level_extract;
  localparam int DW = 16, LV = 3, NC = 16, IW = 4, CW = 19, NS = 128;

  logic clk = 1'b0, Reset = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic signed [DW-1:0] in_data = '0;
  logic [IW-1:0] rd_addr = '0;
  logic in_ready, busy, done, q_flag, q_empty, s_flag, s_empty;
  logic [IW-1:0] max_pos, min_pos, q_begin, s_end;
  logic signed [CW-1:0] rd_data;

  haar_level_extract #(.DATA_W(DW), .LEVEL(LV), .N_COEF(NC), .Q_WIN(4), .S_WIN(4)) dut (
    .clk(clk), .Reset(Reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy), .done(done), .max_pos(max_pos), .min_pos(min_pos),
    .q_begin(q_begin), .q_flag(q_flag), .q_empty(q_empty), .s_end(s_end), .s_flag(s_flag),
    .s_empty(s_empty), .rd_addr(rd_addr), .rd_data(rd_data));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] max_pos, min_pos, q_begin, s_end;
    logic q_flag, q_empty, s_flag, s_empty, done, busy;
  } res_t;

  int samples [NS];
  int m_ca [NC];
  int m_cd [NC];
  res_t exp_r, got_r, first_r;
  int exp_cyc, got_cyc, v;
  logic [5:0] post_start;
  int n_tests = 0, n_fail = 0;

  // Reference: block sums, strict-compare extrema, windowed searches, cycle cost.
  task automatic model();
    int a, b, mx, mn, first, last, lo, hi, qb, sb, qc, sc;
    bit qe, se;
    for (int k = 0; k < NC; k++) begin
      a = 0; b = 0;
      for (int j = 0; j < 4; j++) a += samples[8*k + j];
      for (int j = 4; j < 8; j++) b += samples[8*k + j];
      m_ca[k] = a + b; m_cd[k] = a - b;
    end
    mx = 0; mn = 0;
    for (int k = 1; k < NC; k++)
      if (m_cd[k] > m_cd[mx]) mx = k;
      else if (m_cd[k] < m_cd[mn]) mn = k;
    first = (mx < mn) ? mx : mn;
    last  = (mx < mn) ? mn : mx;
    lo = (first - 4 < 0) ? 0 : first - 4; hi = first - 1;
    if (hi < lo) begin qb = first; qe = 1; qc = 1; end
    else begin
      qb = lo; qe = 0; qc = hi - lo + 2;
      for (int j = lo + 1; j <= hi; j++) if (m_cd[j] > m_cd[qb]) qb = j;
    end
    lo = last + 1; hi = (last + 4 > NC - 1) ? NC - 1 : last + 4;
    if (hi < lo) begin sb = last; se = 1; sc = 1; end
    else begin
      sb = lo; se = 0; sc = hi - lo + 2;
      for (int j = lo + 1; j <= hi; j++) if (m_cd[j] < m_cd[sb]) sb = j;
    end
    exp_r.max_pos = 4'(mx); exp_r.min_pos = 4'(mn);
    exp_r.q_begin = 4'(qb); exp_r.s_end = 4'(sb);
    exp_r.q_flag = 1'b1; exp_r.q_empty = qe; exp_r.s_flag = 1'b1; exp_r.s_empty = se;
    exp_r.done = 1'b1; exp_r.busy = 1'b0;
    exp_cyc = qc + sc;
  endtask

  task automatic collect();
    got_r.max_pos = max_pos; got_r.min_pos = min_pos;
    got_r.q_begin = q_begin; got_r.s_end = s_end;
    got_r.q_flag = q_flag; got_r.q_empty = q_empty;
    got_r.s_flag = s_flag; got_r.s_empty = s_empty;
    got_r.done = done; got_r.busy = busy;
  endtask

  task automatic read_ca(input int a, output int val);
    rd_addr = IW'(a);
    @(posedge clk); #1;
    val = int'(rd_data);
  endtask

  // Start, stream the record (optionally with bubbles / a stray start), then time the searches.
  task automatic run_record(input bit bub, input bit smid);
    int i, cyc;
    bit tog, acc;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    post_start = {q_flag, s_flag, q_empty, s_empty, done, in_ready};
    i = 0; cyc = 0; tog = 1'b0;
    while (i < NS && cyc < 2000) begin
      in_valid = bub ? tog : 1'b1; tog = !tog;
      in_data  = DW'(samples[i]);
      start    = smid && (i == 40);
      acc      = in_valid && in_ready;
      @(posedge clk); #1; cyc++;
      if (acc) i++;
    end
    in_valid = 1'b0; start = 1'b0;
    got_cyc = 0;
    while (!done && got_cyc < 200) begin @(posedge clk); #1; got_cyc++; end
    collect();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk); #1;
    n_tests++;
    if ({in_ready, busy, done, max_pos, min_pos, q_begin, q_flag, q_empty, s_end, s_flag, s_empty, rd_data} !== '0) begin
      n_fail++; $display("FAIL reset_held got=%b/%b/%b pos=%0d/%0d q=%0d s=%0d rd=%0d required all 0",
                         in_ready, busy, done, max_pos, min_pos, q_begin, s_end, rd_data);
    end
    Reset = 1'b0; @(posedge clk); #1;
    n_tests++;
    if ({in_ready, busy, done, q_flag, q_empty, s_flag, s_empty} !== 7'b0) begin
      n_fail++; $display("FAIL reset_idle got=%b%b%b%b%b%b%b required 0000000",
                         in_ready, busy, done, q_flag, q_empty, s_flag, s_empty);
    end
  endtask

  task automatic test_constant();
    for (int i = 0; i < NS; i++) samples[i] = 10;
    run_record(0, 0); model();
    n_tests++;
    if (got_r !== exp_r) begin n_fail++; $display("FAIL const_res got=%h required %h", got_r, exp_r); end
    n_tests++;
    if ({max_pos, min_pos, q_begin, q_empty, s_end, s_empty} !== {4'd0, 4'd0, 4'd0, 1'b1, 4'd1, 1'b0}) begin
      n_fail++; $display("FAIL const_lit got max=%0d min=%0d q=%0d qe=%b s=%0d se=%b required 0 0 0 1 1 0",
                         max_pos, min_pos, q_begin, q_empty, s_end, s_empty);
    end
    for (int a = 0; a < NC; a++) begin
      read_ca(a, v); n_tests++;
      if (v != 80) begin n_fail++; $display("FAIL const_ca[%0d] got=%0d required 80", a, v); end
    end
  endtask

  task automatic test_impulses();
    for (int i = 0; i < NS; i++) samples[i] = 0;
    samples[48] = 100; samples[76] = 50;
    run_record(0, 0); model();
    n_tests++;
    if (got_r !== exp_r) begin n_fail++; $display("FAIL imp_res got=%h required %h", got_r, exp_r); end
    n_tests++;
    if ({max_pos, min_pos, q_begin, s_end} !== {4'd6, 4'd9, 4'd2, 4'd10}) begin
      n_fail++; $display("FAIL imp_lit got max=%0d min=%0d q=%0d s=%0d required 6 9 2 10",
                         max_pos, min_pos, q_begin, s_end);
    end
    n_tests++;
    if (got_cyc != 10) begin n_fail++; $display("FAIL imp_latency got=%0d required 10", got_cyc); end
    for (int a = 0; a < NC; a++) begin
      read_ca(a, v); n_tests++;
      if (v != m_ca[a]) begin n_fail++; $display("FAIL imp_ca[%0d] got=%0d required %0d", a, v, m_ca[a]); end
    end
  endtask

  task automatic test_full_neg();
    for (int i = 0; i < NS; i++) samples[i] = -32768;
    run_record(0, 0); model();
    n_tests++;
    if (got_r !== exp_r) begin n_fail++; $display("FAIL neg_res got=%h required %h", got_r, exp_r); end
    for (int a = 0; a < NC; a++) begin
      read_ca(a, v); n_tests++;
      if (v != -262144) begin n_fail++; $display("FAIL neg_ca[%0d] got=%0d required -262144", a, v); end
    end
  endtask

  task automatic test_late_max();
    for (int i = 0; i < NS; i++) samples[i] = 0;
    samples[120] = 7;
    run_record(0, 0);
    n_tests++;
    if ({max_pos, min_pos, q_begin, q_empty, s_end, s_empty, q_flag, s_flag} !==
        {4'd15, 4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL late_lit got max=%0d min=%0d q=%0d qe=%b s=%0d se=%b required 15 0 0 1 15 1",
                         max_pos, min_pos, q_begin, q_empty, s_end, s_empty);
    end
    n_tests++;
    if (got_cyc != 2) begin n_fail++; $display("FAIL late_latency got=%0d required 2", got_cyc); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NS; i++)
        samples[i] = (r < 2) ? int'($urandom_range(0, 2000)) - 1000 : int'($urandom_range(0, 65535)) - 32768;
      run_record(0, 0); model();
      n_tests++;
      if (got_r !== exp_r) begin n_fail++; $display("FAIL rand%0d_res got=%h required %h", r, got_r, exp_r); end
      n_tests++;
      if (got_cyc != exp_cyc) begin n_fail++; $display("FAIL rand%0d_latency got=%0d required %0d", r, got_cyc, exp_cyc); end
      for (int a = 0; a < NC; a += 5) begin
        read_ca(a, v); n_tests++;
        if (v != m_ca[a]) begin n_fail++; $display("FAIL rand%0d_ca[%0d] got=%0d required %0d", r, a, v, m_ca[a]); end
      end
    end
  endtask

  task automatic test_bubbles_restart();
    for (int i = 0; i < NS; i++) samples[i] = int'($urandom_range(0, 600)) - 300;
    model();
    run_record(0, 0);
    first_r = got_r;
    n_tests++;
    if (got_r !== exp_r) begin n_fail++; $display("FAIL bub_plain got=%h required %h", got_r, exp_r); end
    run_record(1, 1);
    n_tests++;
    if (post_start !== 6'b000001) begin
      n_fail++; $display("FAIL restart_clear got qf,sf,qe,se,done,rdy=%b required 000001", post_start);
    end
    n_tests++;
    if (got_r !== first_r) begin n_fail++; $display("FAIL bub_repeat got=%h required %h", got_r, first_r); end
    n_tests++;
    if (got_cyc != exp_cyc) begin n_fail++; $display("FAIL bub_latency got=%0d required %0d", got_cyc, exp_cyc); end
    for (int a = 0; a < NC; a += 3) begin
      read_ca(a, v); n_tests++;
      if (v != m_ca[a]) begin n_fail++; $display("FAIL bub_ca[%0d] got=%0d required %0d", a, v, m_ca[a]); end
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'b1; in_data = DW'(int'($urandom_range(0, 200)));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; Reset = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({in_ready, busy, done, q_flag, q_empty, s_flag, s_empty} !== 7'b0) begin
      n_fail++; $display("FAIL midreset_state got=%b%b%b%b%b%b%b required 0000000",
                         in_ready, busy, done, q_flag, q_empty, s_flag, s_empty);
    end
    Reset = 1'b0; @(posedge clk); #1;
    for (int i = 0; i < NS; i++) samples[i] = 10;
    run_record(0, 0); model();
    n_tests++;
    if (got_r !== exp_r) begin n_fail++; $display("FAIL midreset_res got=%h required %h", got_r, exp_r); end
    n_tests++;
    if ({q_begin, q_empty, s_end, s_empty} !== {4'd0, 1'b1, 4'd1, 1'b0}) begin
      n_fail++; $display("FAIL midreset_lit got q=%0d qe=%b s=%0d se=%b required 0 1 1 0",
                         q_begin, q_empty, s_end, s_empty);
    end
    for (int a = 0; a < NC; a += 4) begin
      read_ca(a, v); n_tests++;
      if (v != 80) begin n_fail++; $display("FAIL midreset_ca[%0d] got=%0d required 80", a, v); end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_impulses();
    test_full_neg();
    test_late_max();
    test_random();
    test_bubbles_restart();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, required completion within 1ms");
    $fatal(1);
  end

endmodule
